// File: rtl/matrix_load_ctrl_pkg.sv
// Shared types and helpers for the matrix load controller.
package matrix_pkg;

    // Controller states; encodings are visible on state_o.
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoadA = 3'd1,
        StLoadB = 3'd2,
        StReady = 3'd3,
        StCalc  = 3'd4,
        StDone  = 3'd5
    } state_e;

    // Number of switch beats needed to fill one DIM x DIM matrix.
    function automatic int unsigned calc_nb(input int unsigned dim, input int unsigned ew,
                                            input int unsigned sw);
        return (dim * dim * ew) / sw;
    endfunction

endpackage

// File: rtl/matrix_load_ctrl_if.sv
// Bus bundle between the matrix load controller and its surroundings.
interface matrix_load_ctrl_if #(
    parameter int unsigned DIM = 2,
    parameter int unsigned EW  = 4,
    parameter int unsigned SW  = 16
);
    import matrix_pkg::*;

    localparam int unsigned NE = DIM * DIM;
    localparam int unsigned NB = calc_nb(DIM, EW, SW);
    localparam int unsigned BW = $clog2(NB) + 1;

    logic             load_btn;
    logic             start_btn;
    logic             clear_btn;
    logic [SW-1:0]    switches;
    logic             calc_done;
    logic [NE*EW-1:0] a_flat;
    logic [NE*EW-1:0] b_flat;
    logic             calc_start;
    logic             busy;
    logic             ready;
    logic [2:0]       state_o;
    logic [BW-1:0]    beat_idx;
    logic             load_pulse_out;

    // Environment side: drives buttons/data, observes results.
    modport master (
        output load_btn, start_btn, clear_btn, switches, calc_done,
        input  a_flat, b_flat, calc_start, busy, ready, state_o, beat_idx, load_pulse_out
    );

    // Controller side.
    modport slave (
        input  load_btn, start_btn, clear_btn, switches, calc_done,
        output a_flat, b_flat, calc_start, busy, ready, state_o, beat_idx, load_pulse_out
    );

endinterface

// File: rtl/matrix_load_ctrl_btn_edge.sv
// Two-flop button synchroniser with rising-edge pulse.
module btn_edge (
    input  logic clk,
    input  logic nRST,
    input  logic btn_i,
    output logic pulse_o
);

    logic q1_q, q2_q;
    logic primed_q, armed_q;

    // Sync chain; armed_q blanks the first two cycles after reset so a button
    // held through reset cannot look like a fresh press.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            q1_q     <= 1'b0;
            q2_q     <= 1'b0;
            primed_q <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            q1_q     <= btn_i;
            q2_q     <= q1_q;
            primed_q <= 1'b1;
            armed_q  <= primed_q;
        end
    end

    assign pulse_o = q1_q & ~q2_q & armed_q;

endmodule

// File: rtl/matrix_load_ctrl.sv
// Loads two matrices beat by beat from switches, then hands off to compute.
module matrix_load_ctrl
    import matrix_pkg::*;
#(
    parameter int unsigned DIM = 2,
    parameter int unsigned EW  = 4,
    parameter int unsigned SW  = 16
) (
    input logic               clk,
    input logic               nRST,
    matrix_load_ctrl_if.slave bus
);

    localparam int unsigned NE  = DIM * DIM;
    localparam int unsigned EPB = SW / EW;
    localparam int unsigned NB  = calc_nb(DIM, EW, SW);
    localparam int unsigned BW  = $clog2(NB) + 1;
    localparam logic [BW-1:0] LastBeat = BW'(NB - 1);

    logic load_pulse, start_pulse, clear_pulse;

    btn_edge u_load (.clk(clk), .nRST(nRST), .btn_i(bus.load_btn), .pulse_o(load_pulse));
    btn_edge u_start (.clk(clk), .nRST(nRST), .btn_i(bus.start_btn), .pulse_o(start_pulse));
    btn_edge u_clear (.clk(clk), .nRST(nRST), .btn_i(bus.clear_btn), .pulse_o(clear_pulse));

    state_e           state_q, state_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [NE*EW-1:0] a_q, a_d, b_q, b_d;
    logic             calc_start_q, busy_q, ready_q;

    logic             wr_en, wr_b;
    logic [BW-1:0]    wr_beat;

    // Next state: clear dominates; a load in IDLE/DONE always writes beat 0 of A.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        a_d     = a_q;
        b_d     = b_q;
        wr_en   = 1'b0;
        wr_b    = 1'b0;
        wr_beat = '0;
        if (clear_pulse) begin
            state_d = StIdle;
            beat_d  = '0;
            a_d     = '0;
            b_d     = '0;
        end else begin
            unique case (state_q)
                StIdle:  wr_en = load_pulse;
                StLoadA: begin
                    wr_en   = load_pulse;
                    wr_beat = beat_q;
                end
                StLoadB: begin
                    wr_en   = load_pulse;
                    wr_b    = 1'b1;
                    wr_beat = beat_q;
                end
                StReady: if (start_pulse) state_d = StCalc;
                StCalc:  if (bus.calc_done) state_d = StDone;
                StDone: begin
                    if (start_pulse) state_d = StCalc;
                    else             wr_en   = load_pulse;
                end
                default: begin
                    state_d = StIdle;
                    beat_d  = '0;
                end
            endcase
            if (wr_en) begin
                // Top slice of the switches lands in the lowest element of the beat.
                for (int unsigned j = 0; j < EPB; j++) begin
                    if (wr_b) b_d[(32'(wr_beat) * EPB + j) * EW +: EW] =
                        bus.switches[SW - 1 - j * EW -: EW];
                    else      a_d[(32'(wr_beat) * EPB + j) * EW +: EW] =
                        bus.switches[SW - 1 - j * EW -: EW];
                end
                if (wr_beat == LastBeat) begin
                    beat_d  = '0;
                    state_d = wr_b ? StReady : StLoadB;
                end else begin
                    beat_d  = wr_beat + 1'b1;
                    state_d = wr_b ? StLoadB : StLoadA;
                end
            end
        end
    end

    // State and registered outputs; calc_start marks the first CALC cycle.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q      <= StIdle;
            beat_q       <= '0;
            a_q          <= '0;
            b_q          <= '0;
            calc_start_q <= 1'b0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            a_q          <= a_d;
            b_q          <= b_d;
            calc_start_q <= (state_d == StCalc) && (state_q != StCalc);
            busy_q       <= (state_d == StCalc);
            ready_q      <= (state_d == StReady);
        end
    end

    assign bus.state_o        = state_q;
    assign bus.beat_idx       = beat_q;
    assign bus.a_flat         = a_q;
    assign bus.b_flat         = b_q;
    assign bus.calc_start     = calc_start_q;
    assign bus.busy           = busy_q;
    assign bus.ready          = ready_q;
    assign bus.load_pulse_out = load_pulse;

endmodule

// File: tb/tb_matrix_load_ctrl.sv
// Bench: DIM=2 and DIM=4 controllers share one input stream, checked against a model.
module tb_matrix_load_ctrl;

    localparam int SIdle = 0, SLoadA = 1, SLoadB = 2, SReady = 3, SCalc = 4, SDone = 5;

    logic        clk = 1'b0;
    logic        nRST;
    logic        load_btn, start_btn, clear_btn, calc_done;
    logic [15:0] switches;

    always #5 clk = ~clk;

    matrix_load_ctrl_if #(.DIM(2), .EW(4), .SW(16)) if2 ();
    matrix_load_ctrl_if #(.DIM(4), .EW(4), .SW(16)) if4 ();

    assign if2.load_btn  = load_btn;
    assign if2.start_btn = start_btn;
    assign if2.clear_btn = clear_btn;
    assign if2.switches  = switches;
    assign if2.calc_done = calc_done;
    assign if4.load_btn  = load_btn;
    assign if4.start_btn = start_btn;
    assign if4.clear_btn = clear_btn;
    assign if4.switches  = switches;
    assign if4.calc_done = calc_done;

    matrix_load_ctrl #(.DIM(2), .EW(4), .SW(16)) dut2 (.clk(clk), .nRST(nRST), .bus(if2));
    matrix_load_ctrl #(.DIM(4), .EW(4), .SW(16)) dut4 (.clk(clk), .nRST(nRST), .bus(if4));

    int n_cmp = 0;
    int n_bad = 0;
    int cs2_seen;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: index 0 is the DIM=2 unit (1 beat/matrix), index 1 the DIM=4 unit (4 beats).
    int ms[2], mbeat[2];
    int ma[2][16], mb[2][16];
    bit mcs[2];
    bit pl, ps, pc, prev_l, prev_s, prev_c;
    int nsince;

    function automatic logic [63:0] pack(input int inst, input bit isb);
        logic [63:0] v = '0;
        for (int i = 0; i < 16; i++) v[i*4 +: 4] = isb ? 4'(mb[inst][i]) : 4'(ma[inst][i]);
        return v;
    endfunction

    task automatic fsm_step(input int inst);
        int nb, pos, v;
        bit tgt;
        nb = (inst == 1) ? 4 : 1;
        mcs[inst] = 1'b0;
        if (pc) begin
            ms[inst] = SIdle;
            mbeat[inst] = 0;
            for (int i = 0; i < 16; i++) begin
                ma[inst][i] = 0;
                mb[inst][i] = 0;
            end
        end else if (ps && (ms[inst] == SReady || ms[inst] == SDone)) begin
            ms[inst] = SCalc;
            mcs[inst] = 1'b1;
        end else if (pl && ms[inst] != SReady && ms[inst] != SCalc) begin
            tgt = (ms[inst] == SLoadB);
            pos = (ms[inst] == SIdle || ms[inst] == SDone) ? 0 : mbeat[inst];
            for (int j = 0; j < 4; j++) begin
                v = (int'(switches) >> (12 - 4 * j)) & 15;
                if (tgt) mb[inst][pos*4 + j] = v;
                else     ma[inst][pos*4 + j] = v;
            end
            if (pos + 1 == nb) begin
                mbeat[inst] = 0;
                ms[inst] = tgt ? SReady : SLoadB;
            end else begin
                mbeat[inst] = pos + 1;
                ms[inst] = tgt ? SLoadB : SLoadA;
            end
        end else if (ms[inst] == SCalc && calc_done) begin
            ms[inst] = SDone;
        end
    endtask

    task automatic model_step();
        if (!nRST) begin
            for (int k = 0; k < 2; k++) begin
                ms[k] = SIdle;
                mbeat[k] = 0;
                mcs[k] = 1'b0;
                for (int i = 0; i < 16; i++) begin
                    ma[k][i] = 0;
                    mb[k][i] = 0;
                end
            end
            {pl, ps, pc, prev_l, prev_s, prev_c} = '0;
            nsince = 0;
        end else begin
            fsm_step(0);
            fsm_step(1);
            nsince++;
            // Pulses need a clean low-to-high seen after reset.
            pl = (nsince >= 2) && load_btn && !prev_l;
            ps = (nsince >= 2) && start_btn && !prev_s;
            pc = (nsince >= 2) && clear_btn && !prev_c;
            prev_l = load_btn;
            prev_s = start_btn;
            prev_c = clear_btn;
        end
    endtask

    task automatic compare_all();
        chk("d2.state", 64'(if2.state_o), 64'(ms[0]));
        chk("d2.beat", 64'(if2.beat_idx), 64'(mbeat[0]));
        chk("d2.a_flat", 64'(if2.a_flat), pack(0, 1'b0));
        chk("d2.b_flat", 64'(if2.b_flat), pack(0, 1'b1));
        chk("d2.calc_start", 64'(if2.calc_start), 64'(mcs[0]));
        chk("d2.busy", 64'(if2.busy), 64'(ms[0] == SCalc));
        chk("d2.ready", 64'(if2.ready), 64'(ms[0] == SReady));
        chk("d2.load_pulse", 64'(if2.load_pulse_out), 64'(pl));
        chk("d4.state", 64'(if4.state_o), 64'(ms[1]));
        chk("d4.beat", 64'(if4.beat_idx), 64'(mbeat[1]));
        chk("d4.a_flat", 64'(if4.a_flat), pack(1, 1'b0));
        chk("d4.b_flat", 64'(if4.b_flat), pack(1, 1'b1));
        chk("d4.calc_start", 64'(if4.calc_start), 64'(mcs[1]));
        chk("d4.busy", 64'(if4.busy), 64'(ms[1] == SCalc));
        chk("d4.ready", 64'(if4.ready), 64'(ms[1] == SReady));
        chk("d4.load_pulse", 64'(if4.load_pulse_out), 64'(pl));
    endtask

    always @(posedge clk) begin
        #1;
        model_step();
        compare_all();
    end

    task automatic press(input bit l, input bit s, input bit c);
        cs2_seen = 0;
        @(negedge clk);
        load_btn = l;
        start_btn = s;
        clear_btn = c;
        repeat (3) begin
            @(negedge clk);
            if (if2.calc_start) cs2_seen++;
        end
        load_btn = 1'b0;
        start_btn = 1'b0;
        clear_btn = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (if2.calc_start) cs2_seen++;
        end
    endtask

    task automatic pulse_done();
        @(negedge clk);
        calc_done = 1'b1;
        @(negedge clk);
        calc_done = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    logic [15:0] vals4[4] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
    int          beats4[4] = '{1, 2, 3, 0};
    int          st4[4] = '{SLoadA, SLoadA, SLoadA, SLoadB};

    initial begin
        nRST = 1'b0;
        {load_btn, start_btn, clear_btn, calc_done} = '0;
        switches = '0;
        repeat (3) @(negedge clk);
        chk("rst.state2", 64'(if2.state_o), 64'(SIdle));
        chk("rst.a2", 64'(if2.a_flat), 64'h0);
        chk("rst.b4", 64'(if4.b_flat), 64'h0);
        chk("rst.busy2", 64'(if2.busy), 64'h0);
        nRST = 1'b1;
        repeat (4) @(negedge clk);

        // Start ignored in IDLE.
        press(1'b0, 1'b1, 1'b0);
        chk("idle_start.state2", 64'(if2.state_o), 64'(SIdle));
        chk("idle_start.cs", 64'(cs2_seen), 64'h0);

        switches = 16'h1234;
        press(1'b1, 1'b0, 1'b0);
        chk("ld1.state2", 64'(if2.state_o), 64'(SLoadB));
        chk("ld1.state4", 64'(if4.state_o), 64'(SLoadA));
        chk("ld1.beat4", 64'(if4.beat_idx), 64'h1);

        // Start ignored in LOAD_A (d4) and LOAD_B (d2).
        press(1'b0, 1'b1, 1'b0);
        chk("ldA_start.state4", 64'(if4.state_o), 64'(SLoadA));
        chk("ldB_start.state2", 64'(if2.state_o), 64'(SLoadB));

        switches = 16'h5678;
        press(1'b1, 1'b0, 1'b0);
        chk("ld2.state2", 64'(if2.state_o), 64'(SReady));
        chk("ld2.a2", 64'(if2.a_flat), 64'h4321);
        chk("ld2.b2", 64'(if2.b_flat), 64'h8765);
        chk("ld2.beat2", 64'(if2.beat_idx), 64'h0);
        chk("ld2.beat4", 64'(if4.beat_idx), 64'h2);

        pulse_done();
        chk("ready_done_ignored", 64'(if2.state_o), 64'(SReady));

        press(1'b0, 1'b1, 1'b0);
        chk("start1.cs_once", 64'(cs2_seen), 64'h1);
        chk("start1.state2", 64'(if2.state_o), 64'(SCalc));
        chk("start1.busy2", 64'(if2.busy), 64'h1);
        repeat (5) @(negedge clk);
        pulse_done();
        chk("done.state2", 64'(if2.state_o), 64'(SDone));
        chk("done.busy2", 64'(if2.busy), 64'h0);

        press(1'b0, 1'b1, 1'b0);
        chk("start2.cs_once", 64'(cs2_seen), 64'h1);
        chk("start2.state2", 64'(if2.state_o), 64'(SCalc));
        pulse_done();

        press(1'b0, 1'b0, 1'b1);
        chk("clr.state4", 64'(if4.state_o), 64'(SIdle));
        chk("clr.a2", 64'(if2.a_flat), 64'h0);

        // Four beats fill A of the DIM=4 unit.
        for (int k = 0; k < 4; k++) begin
            switches = vals4[k];
            press(1'b1, 1'b0, 1'b0);
            chk("d4_beat", 64'(if4.beat_idx), 64'(beats4[k]));
            chk("d4_state", 64'(if4.state_o), 64'(st4[k]));
        end
        chk("d4_full.a", 64'(if4.a_flat), 64'hFEDC_BA98_7654_3210);
        chk("d2_after4.state", 64'(if2.state_o), 64'(SReady));
        chk("d2_after4.a", 64'(if2.a_flat), 64'h3210);
        chk("d2_after4.b", 64'(if2.b_flat), 64'h7654);

        // Clear together with load while d4 sits at LOAD_B beat 0.
        switches = 16'hFFFF;
        press(1'b1, 1'b0, 1'b1);
        chk("clrld.state4", 64'(if4.state_o), 64'(SIdle));
        chk("clrld.a4", 64'(if4.a_flat), 64'h0);
        chk("clrld.b4", 64'(if4.b_flat), 64'h0);
        chk("clrld.state2", 64'(if2.state_o), 64'(SIdle));

        switches = 16'h1234;
        press(1'b1, 1'b0, 1'b0);
        switches = 16'h5678;
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        chk("pre_rst.state2", 64'(if2.state_o), 64'(SCalc));

        // Reset mid-CALC with load held.
        @(negedge clk);
        load_btn = 1'b1;
        repeat (4) @(negedge clk);
        #2 nRST = 1'b0;
        #1;
        chk("arst.state2", 64'(if2.state_o), 64'(SIdle));
        chk("arst.busy2", 64'(if2.busy), 64'h0);
        chk("arst.a2", 64'(if2.a_flat), 64'h0);
        chk("arst.b2", 64'(if2.b_flat), 64'h0);
        chk("arst.a4", 64'(if4.a_flat), 64'h0);
        chk("arst.beat4", 64'(if4.beat_idx), 64'h0);
        @(negedge clk);
        nRST = 1'b1;
        repeat (6) @(negedge clk);
        chk("held.state2", 64'(if2.state_o), 64'(SIdle));
        chk("held.state4", 64'(if4.state_o), 64'(SIdle));
        load_btn = 1'b0;
        repeat (3) @(negedge clk);
        switches = 16'h9ABC;
        press(1'b1, 1'b0, 1'b0);
        chk("repress.state2", 64'(if2.state_o), 64'(SLoadB));
        chk("repress.a2", 64'(if2.a_flat), 64'hCBA9);
        chk("repress.beat4", 64'(if4.beat_idx), 64'h1);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
